// File: rtl/dm_loader_pkg.sv
// Shared types and default widths for the data-memory loader slice.
// Widths track the processor's datamemory/instr_mem buses.
package dm_loader_pkg;

    localparam int DM_ADDR_W = 12;
    localparam int DM_DATA_W = 17;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        RUN     = 3'd3,
        RD_ADDR = 3'd4,
        RD_WAIT = 3'd5,
        OUT     = 3'd6,
        DONE    = 3'd7
    } state_t;

endpackage

// File: rtl/dm_loader_if.sv
// Valid/ready word streams into and out of the loader.
// master = host side (feeds s_*, sinks m_*); slave = the loader.
interface dm_loader_if
    import dm_loader_pkg::*;
#(
    parameter int DATA_W = DM_DATA_W
) ();

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

endinterface

// File: rtl/dm_port_mux.sv
// Steers the data-memory addr/wdata/wr_en between the core and the loader.
// Purely combinational; sel_i=1 gives the loader the port.
module dm_port_mux
    import dm_loader_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
) (
    input  logic              sel_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    input  logic              core_wr_en_i,
    input  logic [ADDR_W-1:0] ldr_addr_i,
    input  logic [DATA_W-1:0] ldr_wdata_i,
    input  logic              ldr_wr_en_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_wr_en_o
);

    assign mem_addr_o  = sel_i ? ldr_addr_i  : core_addr_i;
    assign mem_wdata_o = sel_i ? ldr_wdata_i : core_wdata_i;
    assign mem_wr_en_o = sel_i ? ldr_wr_en_i : core_wr_en_i;

endmodule

// File: rtl/dm_loader.sv
// Preloads data memory from a stream, kicks the core, then dumps a result block.
// Writes land in the s handshake cycle; dump is one word per 3 cycles, held until m_ready.
module dm_loader
    import dm_loader_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_len,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W-1:0] dump_len,
    dm_loader_if.slave        strm,
    output logic              dm_sel,
    output logic              dm_wr_en,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              start_process,
    input  logic              end_process,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] lbase_q, lbase_d, llen_q, llen_d;
    logic [ADDR_W-1:0] dbase_q, dbase_d, dlen_q, dlen_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic              run_arm_q, run_arm_d;
    logic              s_rdy, m_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lbase_q   <= '0;
            llen_q    <= '0;
            dbase_q   <= '0;
            dlen_q    <= '0;
            mdata_q   <= '0;
            run_arm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lbase_q   <= lbase_d;
            llen_q    <= llen_d;
            dbase_q   <= dbase_d;
            dlen_q    <= dlen_d;
            mdata_q   <= mdata_d;
            run_arm_q <= run_arm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lbase_d   = lbase_q;
        llen_d    = llen_q;
        dbase_d   = dbase_q;
        dlen_d    = dlen_q;
        mdata_d   = mdata_q;
        run_arm_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_req) begin
                    lbase_d = load_base;
                    llen_d  = load_len;
                    dbase_d = dump_base;
                    dlen_d  = dump_len;
                    cnt_d   = '0;
                    state_d = (load_len == '0) ? START : LOAD;
                end
            end
            LOAD: begin
                if (strm.s_valid) begin
                    if (cnt_q == llen_q - ADDR_W'(1)) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // The first RUN cycle is blind to end_process so a level left over
                // from the previous run cannot end this one.
                run_arm_d = 1'b1;
                if (run_arm_q && end_process)
                    state_d = (dlen_q == '0) ? DONE : RD_ADDR;
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: begin
                mdata_d = dm_rdata;
                state_d = OUT;
            end
            OUT: begin
                if (strm.m_ready) begin
                    if (cnt_q == dlen_q - ADDR_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = RD_ADDR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dm_sel        = 1'b0;
        dm_wr_en      = 1'b0;
        dm_addr       = '0;
        dm_wdata      = '0;
        s_rdy         = 1'b0;
        m_vld         = 1'b0;
        start_process = 1'b0;
        done          = 1'b0;
        busy          = (state_q != IDLE);
        case (state_q)
            LOAD: begin
                dm_sel   = 1'b1;
                s_rdy    = 1'b1;
                dm_wr_en = strm.s_valid;
                dm_addr  = lbase_q + cnt_q;
                dm_wdata = strm.s_data;
            end
            START: start_process = 1'b1;
            RD_ADDR, RD_WAIT: begin
                dm_sel  = 1'b1;
                dm_addr = dbase_q + cnt_q;
            end
            OUT: begin
                dm_sel  = 1'b1;
                dm_addr = dbase_q + cnt_q;
                m_vld   = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign strm.s_ready = s_rdy;
    assign strm.m_valid = m_vld;
    assign strm.m_data  = mdata_q;

endmodule

// File: tb/tb_dm_loader.sv
// Directed bench for dm_loader with a synchronous-read data-memory model behind dm_port_mux.
module tb_dm_loader;
    import dm_loader_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        load_req;
    logic [11:0] load_base, load_len, dump_base, dump_len;
    logic        dm_sel, dm_wr_en;
    logic [11:0] dm_addr;
    logic [16:0] dm_wdata, dm_rdata;
    logic        start_process, end_process, busy, done;
    logic [11:0] mem_addr;
    logic [16:0] mem_wdata;
    logic        mem_wr_en;
    logic        mem_init;

    dm_loader_if #(.DATA_W(17)) strm ();

    dm_loader #(.ADDR_W(12), .DATA_W(17)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req),
        .load_base(load_base), .load_len(load_len),
        .dump_base(dump_base), .dump_len(dump_len),
        .strm(strm.slave),
        .dm_sel(dm_sel), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .start_process(start_process), .end_process(end_process),
        .busy(busy), .done(done)
    );

    dm_port_mux #(.ADDR_W(12), .DATA_W(17)) u_mux (
        .sel_i(dm_sel),
        .core_addr_i(12'h0), .core_wdata_i(17'h0), .core_wr_en_i(1'b0),
        .ldr_addr_i(dm_addr), .ldr_wdata_i(dm_wdata), .ldr_wr_en_i(dm_wr_en),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wr_en_o(mem_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] pat(input int a);
        return 17'(a * 7 + 3);
    endfunction

    logic [16:0] mem [4096];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
        end
        dm_rdata <= mem[mem_addr];
    end

    logic [11:0] wr_a [$];
    logic [16:0] wr_d [$];
    int n_start = 0;
    int n_sel   = 0;
    always @(posedge clk) begin
        if (dm_wr_en) begin
            wr_a.push_back(dm_addr);
            wr_d.push_back(dm_wdata);
        end
        if (start_process) n_start++;
        if (dm_sel) n_sel++;
    end

    int n_chk  = 0;
    int n_pass = 0;
    logic [16:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic req(input logic [11:0] lb, input logic [11:0] ll,
                       input logic [11:0] db, input logic [11:0] dl);
        load_base = lb; load_len = ll; dump_base = db; dump_len = dl;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic stream(input int n, input logic [16:0] first, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                strm.s_valid = 1'b0;
                @(negedge clk);
            end
            strm.s_valid = 1'b1;
            strm.s_data  = first + 17'(i);
            @(negedge clk);
        end
        strm.s_valid = 1'b0;
    endtask

    // Called from START (or RUN); raises end_process only once RUN is past its first cycle.
    task automatic end_pulse();
        @(negedge clk);
        @(negedge clk);
        end_process = 1'b1;
        @(negedge clk);
        end_process = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic recv(input string tag, input int n, input bit rnd);
        int idx = 0;
        int t = 0;
        bit stall = 1'b0;
        logic [16:0] held = '0;
        while (idx < n && t < 3000) begin
            if (stall) begin
                chk({tag, "_hold_v"}, 32'(strm.m_valid), 32'd1);
                chk({tag, "_hold_d"}, 32'(strm.m_data), 32'(held));
            end
            strm.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (strm.m_valid && strm.m_ready) begin
                chk({tag, "_data"}, 32'(strm.m_data), 32'(exp_q[idx]));
                idx++;
            end
            stall = strm.m_valid && !strm.m_ready;
            held  = strm.m_data;
            @(negedge clk);
            t++;
        end
        strm.m_ready = 1'b0;
        chk({tag, "_cnt"}, 32'(idx), 32'(n));
    endtask

    int w0, s0, sel0;

    initial begin
        rst_n = 1'b0; load_req = 1'b1; mem_init = 1'b1;
        load_base = '0; load_len = '0; dump_base = '0; dump_len = '0;
        end_process = 1'b0;
        strm.s_valid = 1'b0; strm.s_data = '0; strm.m_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset with load_req held high
        chk("rst_busy",   32'(busy), 0);
        chk("rst_wr",     32'(dm_wr_en), 0);
        chk("rst_start",  32'(start_process), 0);
        chk("rst_mvalid", 32'(strm.m_valid), 0);
        chk("rst_sready", 32'(strm.s_ready), 0);
        chk("rst_sel",    32'(dm_sel), 0);
        chk("rst_done",   32'(done), 0);
        mem_init = 1'b0; rst_n = 1'b1; load_req = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        // Gapped 4-word load at 0x010
        w0 = wr_a.size(); s0 = n_start;
        req(12'h010, 12'd4, 12'h0, 12'd0);
        chk("t2_busy", 32'(busy), 1);
        chk("t2_sready", 32'(strm.s_ready), 1);
        chk("t2_nowr_gap", 32'(dm_wr_en), 0);
        stream(4, 17'h00001, 1'b1);
        chk("t2_start", 32'(start_process), 1);
        chk("t2_nwr", 32'(wr_a.size() - w0), 4);
        for (int i = 0; i < 4 && w0 + i < wr_a.size(); i++) begin
            chk("t2_addr", 32'(wr_a[w0+i]), 32'(12'h010 + 12'(i)));
            chk("t2_wdat", 32'(wr_d[w0+i]), 32'(i + 1));
        end
        @(negedge clk);
        chk("t2_start_1cyc", 32'(start_process), 0);
        chk("t2_nstart", 32'(n_start - s0), 1);
        end_pulse();
        wait_done("t2");

        // Zero-length load and dump
        w0 = wr_a.size(); sel0 = n_sel;
        req(12'h0, 12'd0, 12'h0, 12'd0);
        chk("t3_start_now", 32'(start_process), 1);
        repeat (5) @(negedge clk);
        end_process = 1'b1;
        chk("t3_done_pre", 32'(done), 0);
        @(negedge clk);
        end_process = 1'b0;
        chk("t3_done", 32'(done), 1);
        @(negedge clk);
        chk("t3_done_1cyc", 32'(done), 0);
        chk("t3_idle", 32'(busy), 0);
        chk("t3_nwr", 32'(wr_a.size() - w0), 0);
        chk("t3_nsel", 32'(n_sel - sel0), 0);

        // Stale end_process, 16-word throttled dump from 0x000
        end_process = 1'b1;
        req(12'h200, 12'd0, 12'h000, 12'd16);
        chk("t4_start", 32'(start_process), 1);
        @(negedge clk);
        chk("t4_run1_sel", 32'(dm_sel), 0);
        @(negedge clk);
        chk("t4_stale_masked", 32'(dm_sel), 0);
        @(negedge clk);
        chk("t4_rd_sel", 32'(dm_sel), 1);
        chk("t4_rd_addr", 32'(dm_addr), 0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(pat(i));
        recv("t4", 16, 1'b1);
        end_process = 1'b0;
        wait_done("t4");

        // Address wrap 0xFFE..0x001
        w0 = wr_a.size();
        req(12'hFFE, 12'd4, 12'h0, 12'd0);
        stream(4, 17'h00011, 1'b0);
        chk("t5_nwr", 32'(wr_a.size() - w0), 4);
        if (wr_a.size() - w0 == 4) begin
            chk("t5_a0", 32'(wr_a[w0]),   32'h0FFE);
            chk("t5_a1", 32'(wr_a[w0+1]), 32'h0FFF);
            chk("t5_a2", 32'(wr_a[w0+2]), 32'h0000);
            chk("t5_a3", 32'(wr_a[w0+3]), 32'h0001);
            chk("t5_d3", 32'(wr_d[w0+3]), 32'h00014);
        end
        end_pulse();
        wait_done("t5");

        // Reset part-way through a load
        w0 = wr_a.size(); s0 = n_start;
        req(12'h300, 12'd4, 12'h0, 12'd0);
        stream(2, 17'h00021, 1'b0);
        strm.s_valid = 1'b1; strm.s_data = 17'h00023; rst_n = 1'b0;
        @(negedge clk);
        chk("t6_wr_off", 32'(dm_wr_en), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_sready", 32'(strm.s_ready), 0);
        strm.s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_nwr", 32'(wr_a.size() - w0), 3);
        chk("t6_nostart", 32'(n_start - s0), 0);

        // Full round trip after the aborted load
        req(12'h400, 12'd2, 12'h400, 12'd2);
        stream(2, 17'h00031, 1'b0);
        chk("t7_start", 32'(start_process), 1);
        end_pulse();
        exp_q.delete();
        exp_q.push_back(17'h00031);
        exp_q.push_back(17'h00032);
        recv("t7", 2, 1'b0);
        wait_done("t7");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
